// File: rtl/ahbl_master_mux_2.sv
// Two-port AHB-Lite master multiplexer: each port parks one address phase in a
// holding register, and a round-robin (or fixed M0-first) grant issues them downstream.
module ahbl_master_mux_2 (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        RR,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [31:0] M0_HWDATA,
  output logic        M0_HREADY,
  output logic [31:0] M0_HRDATA,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [31:0] M1_HWDATA,
  output logic        M1_HREADY,
  output logic [31:0] M1_HRDATA,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA
);

  logic [1:0]  pend, pend_d;
  logic [1:0]  dph, dph_d;
  logic [31:0] addr_q [2];
  logic [31:0] addr_d [2];
  logic [1:0]  write_q, write_d;
  logic [2:0]  size_q [2];
  logic [2:0]  size_d [2];
  logic        last_g, last_d;
  logic        hold, hold_g;
  logic        g, sel, any_pend;
  logic [1:0]  m_ready, m_req, m_hwrite;
  logic [31:0] m_haddr [2];
  logic [2:0]  m_hsize [2];

  // Only HTRANS[1] is acted on; bit 0 (SEQ vs NONSEQ, BUSY vs IDLE) is dropped.
  logic unused_htrans_lsb;
  assign unused_htrans_lsb = ^{M0_HTRANS[0], M1_HTRANS[0]};

  assign m_haddr[0] = M0_HADDR;
  assign m_haddr[1] = M1_HADDR;
  assign m_hsize[0] = M0_HSIZE;
  assign m_hsize[1] = M1_HSIZE;
  assign m_hwrite   = {M1_HWRITE, M0_HWRITE};
  assign m_req      = {M1_HTRANS[1], M0_HTRANS[1]};
  assign any_pend   = |pend;
  assign m_ready    = ~pend & (~dph | {2{HREADY}});

  // Grant is frozen while the presented transfer sits in slave wait states.
  always_comb begin
    if (hold)               g = hold_g;
    else if (pend == 2'b11) g = RR ? ~last_g : 1'b0;
    else                    g = pend[1];
  end

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend    <= '0;
      dph     <= '0;
      last_g  <= 1'b1;
      hold    <= 1'b0;
      hold_g  <= 1'b0;
      write_q <= '0;
      // NOTE: holding registers are reset because idle HADDR/HSIZE show them and must read zero.
      for (int i = 0; i < 2; i++) begin
        addr_q[i] <= '0;
        size_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      pend    <= pend_d;
      dph     <= dph_d;
      last_g  <= last_d;
      hold    <= any_pend & ~HREADY;
      hold_g  <= g;
      write_q <= write_d;
      for (int i = 0; i < 2; i++) begin
        addr_q[i] <= addr_d[i];
        size_q[i] <= size_d[i];
      end
    end
  end

  // Next-state: issue of the granted master, then per-port capture
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
    pend_d  = pend;
    dph_d   = dph;
    last_d  = last_g;
    write_d = write_q;
    for (int i = 0; i < 2; i++) begin
      addr_d[i] = addr_q[i];
      size_d[i] = size_q[i];
    end
    if (HREADY) begin
      dph_d = '0;
      if (any_pend) begin
        pend_d[g] = 1'b0;
        dph_d[g]  = 1'b1;
        last_d    = g;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (m_ready[i] && m_req[i]) begin
        pend_d[i]  = 1'b1;
        addr_d[i]  = m_haddr[i];
        write_d[i] = m_hwrite[i];
        size_d[i]  = m_hsize[i];
      end
    end
  end

  // Outputs: SEQ bursts leave as NONSEQ singles; idle bus keeps the last winner's address.
  always_comb begin
    sel       = any_pend ? g : last_g;
    HTRANS    = any_pend ? 2'b10 : 2'b00;
    HADDR     = addr_q[sel];
    HWRITE    = write_q[sel];
    HSIZE     = size_q[sel];
    HWDATA    = dph[0] ? M0_HWDATA : (dph[1] ? M1_HWDATA : 32'h0);
    M0_HREADY = m_ready[0];
    M1_HREADY = m_ready[1];
    M0_HRDATA = HRDATA;
    M1_HRDATA = HRDATA;
  end

endmodule
